// File: rtl/iob_iob2axi_read_split_pkg.sv
// Shared definitions for the IOB-to-AXI read burst splitter.
package iob_iob2axi_read_split_pkg;

  // Splitter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // AXI bursts must not cross a 4 KB page: 12 low address bits
  localparam int BOUND_W     = 12;
  localparam int BOUND_BYTES = 1 << BOUND_W;

  // Largest of three widths, used to size intermediate comparisons
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/iob_iob2axi_burst_len.sv
// Beat count of the next burst: the smallest of the beats still to read,
// the AXI maximum burst length and the beats left before the 4 KB page end.
module iob_iob2axi_burst_len
  import iob_iob2axi_read_split_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = 8,
  parameter int NWORDS_W  = 24
) (
  input  logic [NWORDS_W:0]  remaining_i,
  input  logic [BOUND_W-1:0] addr_lo_i,
  output logic [NWORDS_W:0]  beats_o
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CW    = max3(NWORDS_W + 1, AXI_LEN_W + 1, BOUND_W + 1);

  logic [BOUND_W:0] room_bytes;
  logic [CW-1:0]    rem_w;
  logic [CW-1:0]    maxb_w;
  logic [CW-1:0]    room_w;
  logic [CW-1:0]    min_w;

  // Minimum of the three limits, computed wide enough that MAXB never truncates
  always_comb begin
    room_bytes = (BOUND_W + 1)'(BOUND_BYTES) - {1'b0, addr_lo_i};
    rem_w      = CW'(remaining_i);
    maxb_w     = CW'(1) << AXI_LEN_W;
    room_w     = CW'(room_bytes >> OFF_W);
    min_w      = rem_w;
    if (maxb_w < min_w) min_w = maxb_w;
    if (room_w < min_w) min_w = room_w;
    beats_o    = (NWORDS_W + 1)'(min_w);
  end

endmodule

// File: rtl/iob_iob2axi_read_split.sv
// Splits a linear read of nwords beats into AXI-legal bursts (at most
// 2^AXI_LEN_W beats, never crossing a 4 KB page) and hands them one at a
// time to a downstream read engine using a run/ready handshake.
module iob_iob2axi_read_split
  import iob_iob2axi_read_split_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = 8,
  parameter int NWORDS_W  = 24
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [NWORDS_W-1:0]  nwords_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 run_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [AXI_LEN_W-1:0] length_o,
  input  logic                 ready_i,
  input  logic                 error_i
);

  localparam int                OFF_W      = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);

  state_t               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [NWORDS_W:0]    rem_q;
  logic [NWORDS_W:0]    beats_q;
  logic                 abort_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic                 run_q;
  logic [ADDR_W-1:0]    addr_o_q;
  logic [AXI_LEN_W-1:0] len_q;

  logic [NWORDS_W:0]    beats_d;
  logic [AXI_LEN_W-1:0] len_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [NWORDS_W:0]    rem_d;

  iob_iob2axi_burst_len #(
    .DATA_W   (DATA_W),
    .AXI_LEN_W(AXI_LEN_W),
    .NWORDS_W (NWORDS_W)
  ) u_burst_len (
    .remaining_i(rem_q),
    .addr_lo_i  (addr_q[BOUND_W-1:0]),
    .beats_o    (beats_d)
  );

  // Burst field for the next request, and the pointers after the current burst
  always_comb begin
    len_d  = AXI_LEN_W'(beats_d - (NWORDS_W + 1)'(1));
    addr_d = addr_q + (ADDR_W'(beats_q) << OFF_W);
    rem_d  = rem_q - beats_q;
  end

  // Control FSM; every output is a register updated on state transitions
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      beats_q  <= '0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      run_q    <= 1'b0;
      addr_o_q <= '0;
      len_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && abort_i) abort_q <= 1'b1;
      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          if (start_i) begin
            error_q <= 1'b0;
            if (nwords_i != '0) begin
              addr_q  <= base_addr_i & ALIGN_MASK;
              rem_q   <= {1'b0, nwords_i};
              busy_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        CALC: begin
          beats_q  <= beats_d;
          addr_o_q <= addr_q;
          len_q    <= len_d;
          run_q    <= 1'b1;
          state_q  <= ISSUE;
        end
        ISSUE: begin
          // Engine dropping ready is taken as acceptance of the burst
          if (!ready_i) begin
            run_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (ready_i) begin
            error_q <= error_q | error_i;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            if ((rem_d == '0) || error_i || abort_q || abort_i) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              abort_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign error_o  = error_q;
  assign run_o    = run_q;
  assign addr_o   = addr_o_q;
  assign length_o = len_q;

endmodule
